mix_tree_sequencer: RTL and testbench
=====================================

# mix_tree_sequencer

Timed controller for a binary mixing tree built from `mixer`/`chamber` stages, one tree row per level. On `start` it runs each level in order through fill, mix and transfer, then hands the product to the output chamber. It drives per-level inlet valve, mixer pump and outlet valve enables. It sits between the host command interface and the valve/pump actuator drivers.

## Interface
- `LEVELS`, 6: number of tree rows sequenced; must be ≥1.
- `CNT_W`, 16: width of the phase-duration counters.
- `LVL_W`, `$clog2(LEVELS)` (min 1): width of `level`. Derived, not overridable.

- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin run; sampled only in IDLE.
- `abort` in 1: abandon run and flush; sampled only while busy.
- `fill_cyc` in CNT_W: fill-phase duration in cycles; latched on accepted `start`.
- `mix_cyc` in CNT_W: mix-phase duration; latched on `start`.
- `xfer_cyc` in CNT_W: transfer/flush duration; latched on `start`.
- `pause` in 1: hold current phase; present only with `MTS_PAUSE_EN`.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse on normal completion.
- `aborted` out 1: one-cycle pulse when a flush completes.
- `level` out LVL_W: index of the active level; 0 in IDLE.
- `inlet_vlv` out LEVELS: one-hot inlet valve enable for the active level.
- `mix_pump` out LEVELS: one-hot mixer pump enable.
- `outlet_vlv` out LEVELS: one-hot outlet enable; all ones during FLUSH.

## Operation
- States: IDLE, FILL, MIX, XFER, FLUSH.
- IDLE → FILL on `start`. Durations are latched and `level` is set to 0.
- FILL → MIX → XFER, each after its latched duration expires.
- XFER expiry with `level` < LEVELS-1: increment `level` and go to FILL.
- XFER expiry with `level` = LEVELS-1: go to IDLE and pulse `done`.
- Any busy state except FLUSH, with `abort`: go to FLUSH. Load `xfer_cyc`, keep `level`.
- FLUSH expiry: go to IDLE, pulse `aborted`, clear `level` to 0.
- A duration of N means exactly N cycles in that phase; N=0 is treated as 1.
- Each output bit is active only in its own phase, on bit [`level`]. All bits are 0 in IDLE.
- `start` while busy: ignored. `abort` in IDLE or FLUSH: ignored.
- `abort` on the final XFER expiry cycle: abort wins. Go to FLUSH, no `done`.
- `start` and `abort` together in IDLE: `start` accepted, `abort` ignored.
- Reset value of every output: 0. State is IDLE, counter is 0.
- `rst_n` low mid-run: all valves and pumps deassert immediately, without waiting for `clk`.

## Timing
- All outputs are registered.
- `start` accepted at edge t: FILL outputs and `busy` are visible from cycle t+1.
- A normal run occupies LEVELS·(F+M+X) busy cycles.
- `done` is high in the first IDLE cycle, when `busy` is already 0.
- Phase change is glitch-free: the old enable drops in the same cycle the new one rises. There is no overlap and no gap cycle.
- `abort` sampled at edge t: FLUSH outputs appear at t+1 and last X cycles. `aborted` is high in the following IDLE cycle.

## Configuration
- `MTS_PAUSE_EN` defined:
  - `pause` port exists.
  - While `pause`=1 in FILL, MIX, XFER or FLUSH: counter holds, state holds, outputs are unchanged (valves stay as they are).
  - `abort` is still honoured while paused.
  - `pause` has no effect in IDLE.
- `MTS_PAUSE_EN` undefined: no `pause` port; the counter always runs.

## Structure
- Package `mts_pkg` holds:
  - the state enum `mts_state_t` (IDLE, FILL, MIX, XFER, FLUSH);
  - the zero-to-one duration clamp as a function;
  - the default parameter constants.
- Sub-module `mts_phase_timer`:
  - loadable down-counter, CNT_W wide;
  - inputs `load`/`value`, plus `hold` (tied 0 without the macro);
  - output `expire`, high on the last cycle of the phase.
- The top level holds the FSM, the level counter and the one-hot output decode.

## Test plan
- LEVELS=3, F=2, M=3, X=1, `start` at cycle 0:
  - `inlet_vlv`=001 in cycles 1–2, `mix_pump`=001 in 3–5, `outlet_vlv`=001 in 6;
  - `inlet_vlv`=010 in 7–8;
  - `busy` high in 1–18, `done` pulse in 19.
- Same config, `abort` at cycle 8 (level 1 FILL):
  - `outlet_vlv`=111 in cycle 9;
  - `aborted` pulse in 10, `done` never asserts, `level`=0 in 10.
- `fill_cyc`=0, M=1, X=1, LEVELS=1: FILL lasts 1 cycle; `done` at cycle 4.
- `start` pulsed again at cycle 5 of a run: ignored; run timing identical to the first scenario.
- `rst_n` low at cycle 4 (mid-MIX): `mix_pump`=0 before the next edge; after release, IDLE with all outputs 0.
- `MTS_PAUSE_EN`, `pause` high in cycles 3–5: first MIX extends to cycles 3–8; `done` moves to cycle 22.

Source files
------------

// File: rtl/mts_pkg.sv
// Shared types and helpers for the mixing-tree sequencer.
package mts_pkg;

  localparam int MTS_LEVELS_DEF = 6;
  localparam int MTS_CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_MIX,
    S_XFER,
    S_FLUSH
  } mts_state_t;

  // A programmed duration of zero still occupies one cycle.
  function automatic logic [31:0] dur_clamp(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/mts_phase_timer.sv
// Loadable phase down-counter; expire marks the final cycle of the loaded phase.
module mts_phase_timer
  import mts_pkg::*;
#(
  parameter int CNT_W = MTS_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             hold,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= '0;
    else if (load)                 cnt <= CNT_W'(dur_clamp(32'(value)));
    else if (!hold && cnt != '0)   cnt <= cnt - CNT_W'(1);
  end

  assign expire = (cnt == CNT_W'(1)) && !hold;

endmodule

// File: rtl/mix_tree_sequencer.sv
// Fill/mix/transfer sequencer for a binary mixing tree, one row per level.
// Optional pause input is compiled in with MTS_PAUSE_EN.
module mix_tree_sequencer
  import mts_pkg::*;
#(
  parameter  int LEVELS = MTS_LEVELS_DEF,
  parameter  int CNT_W  = MTS_CNT_W_DEF,
  localparam int LVL_W  = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  fill_cyc,
  input  logic [CNT_W-1:0]  mix_cyc,
  input  logic [CNT_W-1:0]  xfer_cyc,
`ifdef MTS_PAUSE_EN
  input  logic              pause,
`endif
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [LVL_W-1:0]  level,
  output logic [LEVELS-1:0] inlet_vlv,
  output logic [LEVELS-1:0] mix_pump,
  output logic [LEVELS-1:0] outlet_vlv
);

  mts_state_t       state, nxt_state;
  logic [LVL_W-1:0] nxt_level;
  logic [CNT_W-1:0] fill_q, mix_q, xfer_q;
  logic [CNT_W-1:0] load_val;
  logic             load, expire, hold, last, done_n, abd_n;
  logic [LEVELS-1:0] sel;

`ifdef MTS_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  mts_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .value  (load_val),
    .hold   (hold),
    .expire (expire)
  );

  assign last = (level == LVL_W'(LEVELS - 1));

  always_comb begin
    nxt_state = state;
    nxt_level = level;
    load      = 1'b0;
    load_val  = xfer_q;
    done_n    = 1'b0;
    abd_n     = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        nxt_state = S_FILL;
        nxt_level = '0;
        load      = 1'b1;
        load_val  = fill_cyc;
      end
      S_FILL, S_MIX, S_XFER: begin
        // Abort outranks every expiry, including the final transfer.
        if (abort) begin
          nxt_state = S_FLUSH;
          load      = 1'b1;
          load_val  = xfer_q;
        end else if (expire) begin
          load = 1'b1;
          if (state == S_FILL) begin
            nxt_state = S_MIX;
            load_val  = mix_q;
          end else if (state == S_MIX) begin
            nxt_state = S_XFER;
            load_val  = xfer_q;
          end else if (last) begin
            nxt_state = S_IDLE;
            nxt_level = '0;
            load      = 1'b0;
            done_n    = 1'b1;
          end else begin
            nxt_state = S_FILL;
            nxt_level = level + LVL_W'(1);
            load_val  = fill_q;
          end
        end
      end
      S_FLUSH: if (expire) begin
        nxt_state = S_IDLE;
        nxt_level = '0;
        abd_n     = 1'b1;
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_level = '0;
      end
    endcase
  end

  assign sel = LEVELS'(1) << nxt_level;

  // Outputs are decoded from the next state so enables switch on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      level      <= '0;
      fill_q     <= '0;
      mix_q      <= '0;
      xfer_q     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      inlet_vlv  <= '0;
      mix_pump   <= '0;
      outlet_vlv <= '0;
    end else begin
      state      <= nxt_state;
      level      <= nxt_level;
      if (state == S_IDLE && start) begin
        fill_q <= fill_cyc;
        mix_q  <= mix_cyc;
        xfer_q <= xfer_cyc;
      end
      busy       <= (nxt_state != S_IDLE);
      done       <= done_n;
      aborted    <= abd_n;
      inlet_vlv  <= (nxt_state == S_FILL) ? sel : '0;
      mix_pump   <= (nxt_state == S_MIX)  ? sel : '0;
      outlet_vlv <= (nxt_state == S_XFER)  ? sel :
                    (nxt_state == S_FLUSH) ? {LEVELS{1'b1}} : '0;
    end
  end

endmodule

// File: tb/tb_mix_tree_sequencer.sv
// Directed bench: three-level sequencer plus a one-level instance for the zero-duration case.
module tb_mix_tree_sequencer;

  localparam int NC = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, start1 = 1'b0;
  logic [15:0] fill_cyc = 16'd2, mix_cyc = 16'd3, xfer_cyc = 16'd1;
`ifdef MTS_PAUSE_EN
  logic        pause = 1'b0;
`endif

  logic       busy, done, aborted;
  logic [1:0] level;
  logic [2:0] inlet_vlv, mix_pump, outlet_vlv;
  logic       busy1, done1, aborted1, level1, inlet1, mix1, outlet1;

  int n_chk = 0, n_pass = 0;

  logic [2:0] r_in [NC], r_mix [NC], r_out [NC];
  logic [1:0] r_lvl [NC];
  logic       r_busy [NC], r_done [NC], r_abd [NC];
  logic       r1_in [NC], r1_mix [NC], r1_out [NC], r1_busy [NC], r1_done [NC];

  always #5 clk = ~clk;

  mix_tree_sequencer #(.LEVELS(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .fill_cyc(fill_cyc), .mix_cyc(mix_cyc), .xfer_cyc(xfer_cyc),
`ifdef MTS_PAUSE_EN
    .pause(pause),
`endif
    .busy(busy), .done(done), .aborted(aborted), .level(level),
    .inlet_vlv(inlet_vlv), .mix_pump(mix_pump), .outlet_vlv(outlet_vlv)
  );

  mix_tree_sequencer #(.LEVELS(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0),
    .fill_cyc(16'd0), .mix_cyc(16'd1), .xfer_cyc(16'd1),
`ifdef MTS_PAUSE_EN
    .pause(1'b0),
`endif
    .busy(busy1), .done(done1), .aborted(aborted1), .level(level1),
    .inlet_vlv(inlet1), .mix_pump(mix1), .outlet_vlv(outlet1)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Cycle c spans posedge c .. posedge c+1; inputs driven just after posedge, outputs sampled at negedge.
  task automatic run(input bit use1, input int abort_at, input int start2_at,
                     input int pause_lo, input int pause_hi);
    for (int c = 0; c < NC; c++) begin
      start  = !use1 && (c == 0 || c == start2_at);
      start1 = use1 && (c == 0);
      abort  = (c == abort_at);
`ifdef MTS_PAUSE_EN
      pause  = (c >= pause_lo && c <= pause_hi);
`endif
      @(negedge clk);
      r_in[c] = inlet_vlv; r_mix[c] = mix_pump; r_out[c] = outlet_vlv;
      r_lvl[c] = level; r_busy[c] = busy; r_done[c] = done; r_abd[c] = aborted;
      r1_in[c] = inlet1; r1_mix[c] = mix1; r1_out[c] = outlet1;
      r1_busy[c] = busy1; r1_done[c] = done1;
      @(posedge clk); #1;
    end
    start = 1'b0; start1 = 1'b0; abort = 1'b0;
`ifdef MTS_PAUSE_EN
    pause = 1'b0;
`endif
  endtask

  function automatic int cnt_busy();
    int n = 0;
    for (int c = 0; c < NC; c++) n += int'(r_busy[c]);
    return n;
  endfunction

  function automatic int cnt_done();
    int n = 0;
    for (int c = 0; c < NC; c++) n += int'(r_done[c]);
    return n;
  endfunction

  function automatic int cnt_abd();
    int n = 0;
    for (int c = 0; c < NC; c++) n += int'(r_abd[c]);
    return n;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_outs", {inlet_vlv, mix_pump, outlet_vlv}, 0);
    chk("rst_flags", {done, aborted, level}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Normal three-level run
    run(1'b0, -1, -1, -1, -1);
    chk("n_in1", r_in[1], 1);   chk("n_in2", r_in[2], 1);   chk("n_in3", r_in[3], 0);
    chk("n_mix3", r_mix[3], 1); chk("n_mix5", r_mix[5], 1); chk("n_mix6", r_mix[6], 0);
    chk("n_out6", r_out[6], 1); chk("n_out7", r_out[7], 0);
    chk("n_in7", r_in[7], 2);   chk("n_in8", r_in[8], 2);   chk("n_lvl7", r_lvl[7], 1);
    chk("n_out18", r_out[18], 4); chk("n_lvl18", r_lvl[18], 2);
    chk("n_busy0", r_busy[0], 0); chk("n_busy1", r_busy[1], 1);
    chk("n_busy18", r_busy[18], 1); chk("n_busy19", r_busy[19], 0);
    chk("n_busy_cnt", cnt_busy(), 18);
    chk("n_done19", r_done[19], 1); chk("n_done_cnt", cnt_done(), 1);
    chk("n_lvl19", r_lvl[19], 0); chk("n_abd_cnt", cnt_abd(), 0);

    // Abort during level-1 fill
    run(1'b0, 8, -1, -1, -1);
    chk("a_out9", r_out[9], 7); chk("a_in9", r_in[9], 0); chk("a_lvl9", r_lvl[9], 1);
    chk("a_busy9", r_busy[9], 1); chk("a_busy10", r_busy[10], 0);
    chk("a_abd10", r_abd[10], 1); chk("a_abd_cnt", cnt_abd(), 1);
    chk("a_lvl10", r_lvl[10], 0); chk("a_done_cnt", cnt_done(), 0);
    chk("a_out10", r_out[10], 0);

    // Abort on the final transfer cycle wins over done
    run(1'b0, 18, -1, -1, -1);
    chk("af_out19", r_out[19], 7); chk("af_done_cnt", cnt_done(), 0);
    chk("af_abd20", r_abd[20], 1);

    // Second start mid-run is ignored
    run(1'b0, -1, 5, -1, -1);
    chk("s_mix5", r_mix[5], 1); chk("s_out6", r_out[6], 1);
    chk("s_busy_cnt", cnt_busy(), 18); chk("s_done19", r_done[19], 1);
    chk("s_done_cnt", cnt_done(), 1);

    // One level, zero fill duration
    run(1'b1, -1, -1, -1, -1);
    chk("z_in1", r1_in[1], 1); chk("z_in2", r1_in[2], 0);
    chk("z_mix2", r1_mix[2], 1); chk("z_out3", r1_out[3], 1);
    chk("z_done4", r1_done[4], 1); chk("z_busy4", r1_busy[4], 0);

`ifdef MTS_PAUSE_EN
    run(1'b0, -1, -1, 3, 5);
    chk("p_mix3", r_mix[3], 1); chk("p_mix8", r_mix[8], 1); chk("p_mix9", r_mix[9], 0);
    chk("p_out9", r_out[9], 1); chk("p_done22", r_done[22], 1);
    chk("p_done_cnt", cnt_done(), 1); chk("p_busy_cnt", cnt_busy(), 21);
`endif

    // Asynchronous reset in mid-mix
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("r_mix4", mix_pump, 1);
    rst_n = 1'b0;
    #1;
    chk("r_mix_async", mix_pump, 0);
    chk("r_busy_async", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("r_idle_busy", busy, 0);
    chk("r_idle_outs", {inlet_vlv, mix_pump, outlet_vlv}, 0);
    chk("r_idle_lvl", level, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
